// File: rtl/ifu_fetch.sv
// Instruction fetch stage: PC register, req/ack imem port, valid/ready to decode.
// Redirects squash held or in-flight fetches.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4,
  output logic [15:0] imm16,
  output logic [5:0]  opcode,
  output logic [15:0] inst_cnt
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_DISCARD,
    S_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ipc_q, ipc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] tgt;

  assign tgt = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      inst_q  <= '0;
      ipc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_FETCH: begin
        if (imem_ack && !redirect) begin
          inst_d  = imem_rdata;
          ipc_d   = pc_q;
          state_d = S_HOLD;
        end else if (imem_ack && redirect) begin
          pc_d = tgt;
        end else if (redirect) begin
          // keep the open request on the old address; remember target
          pend_d  = tgt;
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (redirect) pend_d = tgt;
        if (imem_ack) begin
          pc_d    = redirect ? tgt : pend_q;
          state_d = S_FETCH;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = tgt;
          state_d = S_FETCH;
        end else if (inst_ready) begin
          pc_d    = pc_q + 32'd4;
          cnt_d   = cnt_q + 16'd1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign imem_req   = (state_q != S_HOLD) && !rst;
  assign imem_addr  = pc_q;
  assign inst_valid = (state_q == S_HOLD);
  assign inst       = inst_q;
  assign inst_pc    = ipc_q;
  assign inst_pc4   = ipc_q + 32'd4;
  assign imm16      = inst_q[15:0];
  assign opcode     = inst_q[31:26];
  assign inst_cnt   = cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a combinational imem model.
// Word at address a reads as (a>>2) ^ 32'hA800_0000.
module tb_ifu_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;
  logic [15:0] imm16;
  logic [5:0]  opcode;
  logic [15:0] inst_cnt;

  int checks;
  int failures;

  ifu_fetch dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst(inst),
    .inst_pc(inst_pc),
    .inst_pc4(inst_pc4),
    .imm16(imm16),
    .opcode(opcode),
    .inst_cnt(inst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rdata = imem_ack ? ((imem_addr >> 2) ^ 32'hA800_0000) : 32'h0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    imem_ack = 1'b0;
    inst_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;

    tick;
    tick;
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_cnt", 32'(inst_cnt), 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_ipc", inst_pc, 32'h0);

    // streaming: ack and ready tied high
    rst = 1'b0;
    imem_ack = 1'b1;
    inst_ready = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("str_req", 32'(imem_req), 32'd1);
      check("str_addr", imem_addr, 32'h3000 + 32'(4 * k));
      check("str_nv", 32'(inst_valid), 32'd0);
      tick;
      check("str_v", 32'(inst_valid), 32'd1);
      check("str_ipc", inst_pc, 32'h3000 + 32'(4 * k));
      check("str_inst", inst, 32'hA800_0C00 + 32'(k));
      check("str_pc4", inst_pc4, 32'h3004 + 32'(4 * k));
      check("str_noreq", 32'(imem_req), 32'd0);
      tick;
    end
    check("str_cnt3", 32'(inst_cnt), 32'd3);
    check("str_addr3", imem_addr, 32'h300C);

    // decode stalls for 5 cycles
    inst_ready = 1'b0;
    tick;
    for (int k = 0; k < 5; k++) begin
      check("st_v", 32'(inst_valid), 32'd1);
      check("st_inst", inst, 32'hA800_0C03);
      check("st_ipc", inst_pc, 32'h300C);
      check("st_imm", 32'(imm16), 32'h0C03);
      check("st_op", 32'(opcode), 32'h2A);
      check("st_req", 32'(imem_req), 32'd0);
      tick;
    end
    inst_ready = 1'b1;
    tick;
    check("st_cnt4", 32'(inst_cnt), 32'd4);
    check("st_addr", imem_addr, 32'h3010);

    // redirect while ack is delayed
    rst = 1'b1;
    imem_ack = 1'b0;
    tick;
    rst = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h0000_4001;
    #1;
    check("dl_addr0", imem_addr, 32'h3000);
    tick;
    redirect = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("dl_addr", imem_addr, 32'h3000);
      check("dl_req", 32'(imem_req), 32'd1);
      check("dl_nv", 32'(inst_valid), 32'd0);
      tick;
    end
    imem_ack = 1'b1;
    #1;
    check("dl_addr_ack", imem_addr, 32'h3000);
    tick;
    check("dl_newaddr", imem_addr, 32'h4000);
    check("dl_nv2", 32'(inst_valid), 32'd0);
    tick;
    check("dl_v", 32'(inst_valid), 32'd1);
    check("dl_ipc", inst_pc, 32'h4000);
    check("dl_inst", inst, 32'hA800_1000);

    // redirect beats ready in HOLD
    redirect = 1'b1;
    redirect_pc = 32'h0000_5000;
    inst_ready = 1'b1;
    tick;
    redirect = 1'b0;
    check("sq_nv", 32'(inst_valid), 32'd0);
    check("sq_cnt", 32'(inst_cnt), 32'd0);
    check("sq_addr", imem_addr, 32'h5000);

    // wrap at the top of the address space
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick;
    redirect = 1'b0;
    check("wr_addr", imem_addr, 32'hFFFF_FFFC);
    check("wr_nv", 32'(inst_valid), 32'd0);
    tick;
    check("wr_v", 32'(inst_valid), 32'd1);
    check("wr_inst", inst, 32'h97FF_FFFF);
    check("wr_op", 32'(opcode), 32'h25);
    check("wr_pc4", inst_pc4, 32'h0);
    tick;
    check("wr_next", imem_addr, 32'h0);
    check("wr_cnt", 32'(inst_cnt), 32'd1);

    // reset in the middle of an open request
    imem_ack = 1'b0;
    rst = 1'b1;
    #1;
    check("mr_req0", 32'(imem_req), 32'd0);
    tick;
    check("mr_req1", 32'(imem_req), 32'd0);
    check("mr_nv", 32'(inst_valid), 32'd0);
    check("mr_cnt", 32'(inst_cnt), 32'd0);
    rst = 1'b0;
    #1;
    check("mr_addr", imem_addr, 32'h3000);
    check("mr_req2", 32'(imem_req), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
